hardware_trigger_gen: RTL and testbench

- Produces the trigger-tagged sample stream consumed by the trigger selector's slave AXIS input. It is the transmitter side of that stream.
- Compares every RFDC sample against a programmable threshold and detects rising crossings.
- On a crossing, emits one frame: a fixed pre-trigger history, the trigger cycle, and a programmable post-trigger tail.
- Each beat carries samples, trigger info, timestamp and trigger config, packed exactly as the selector expects.

---
 rtl/hardware_trigger_gen_pkg.sv | 52 +++++
 rtl/hardware_trigger_gen_delay_line.sv | 40 ++++
 rtl/hardware_trigger_gen.sv | 176 +++++++++++++++++
 tb/tb_hardware_trigger_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hardware_trigger_gen_pkg.sv
// -----------------------------------------------------------------------------
// hardware_trigger_gen_pkg
//   Field widths, trigger-type codes, the FSM state type and the packing
//   helpers for the trigger-tagged beat consumed by the trigger selector.
//   Beat layout, MSB to LSB: {samples, info, timestamp, config}.
//     info   : [FRAME_START_BIT] first beat of frame,
//              [FRAME_END_BIT]   last beat of frame,
//              [TRIGGER_TYPE_WIDTH-1:0] trigger type, all other bits zero.
//     config : {threshold (CFG_FIELD_W), zero-extended post length (CFG_FIELD_W)}
// -----------------------------------------------------------------------------
package hardware_trigger_gen_pkg;

    localparam int RFDC_TDATA_WIDTH     = 128;
    localparam int TRIGGER_INFO_WIDTH   = 8;
    localparam int TRIGGER_TYPE_WIDTH   = 2;
    localparam int TIMESTAMP_WIDTH      = 32;
    localparam int CFG_FIELD_W          = 16;
    localparam int TRIGGER_CONFIG_WIDTH = 2 * CFG_FIELD_W;

    localparam int FRAME_START_BIT = TRIGGER_INFO_WIDTH - 1;
    localparam int FRAME_END_BIT   = TRIGGER_INFO_WIDTH - 2;

    localparam logic [TRIGGER_TYPE_WIDTH-1:0] HARDWARE_TRG = 2'd1;
    localparam logic [TRIGGER_TYPE_WIDTH-1:0] EXTERNAL_TRG = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } trg_state_t;

    // Info word for a hardware-trigger beat; start and end flags are set
    // independently so a one-beat frame would carry both.
    function automatic logic [TRIGGER_INFO_WIDTH-1:0] make_info(
        input logic first,
        input logic last
    );
        logic [TRIGGER_INFO_WIDTH-1:0] info;
        info = '0;
        info[TRIGGER_TYPE_WIDTH-1:0] = HARDWARE_TRG;
        info[FRAME_START_BIT]        = first;
        info[FRAME_END_BIT]          = last;
        return info;
    endfunction

    function automatic logic [TRIGGER_CONFIG_WIDTH-1:0] pack_config(
        input logic [CFG_FIELD_W-1:0] threshold,
        input logic [CFG_FIELD_W-1:0] post_len
    );
        return {threshold, post_len};
    endfunction

endpackage

// File: rtl/hardware_trigger_gen_delay_line.sv
// -----------------------------------------------------------------------------
// sample_delay_line
//   Fixed-depth shift register holding the pre-trigger sample history.
//   The output is the input beat delayed by DEPTH clock cycles.
//   Ports:
//     ACLK     clock
//     ARESETN  asynchronous active-low reset, clears every tap
//     samples  beat entering the line
//     delayed  beat leaving the line (DEPTH cycles old)
// -----------------------------------------------------------------------------
module sample_delay_line
    import hardware_trigger_gen_pkg::*;
#(
    parameter int WIDTH = RFDC_TDATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [WIDTH-1:0] samples,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= samples;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign delayed = taps[DEPTH-1];

endmodule

// File: rtl/hardware_trigger_gen.sv
// -----------------------------------------------------------------------------
// hardware_trigger_gen
//   Threshold trigger on the RFDC sample stream. A rising crossing (any sample
//   of a beat above THRESHOLD where the previous beat had none) starts one
//   contiguous frame: PRE_ACQ_DEPTH history beats, the trigger beat, then
//   POST_ACQ_LEN tail beats. Each beat is tagged with frame flags, the
//   timestamp of the trigger and the configuration in force at the trigger.
//   Ports:
//     ACLK, ARESETN   clock, asynchronous active-low reset
//     SET_CONFIG      load THRESHOLD / POST_ACQ_LEN, aborts a running frame
//     STOP            inhibits new triggers (a running frame completes)
//     THRESHOLD       signed sample threshold
//     POST_ACQ_LEN    post-trigger beats per frame
//     S_AXIS_TDATA    RFDC beat, sample j at [j*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//     M_AXIS_TVALID   frame beat valid
//     M_AXIS_TDATA    {samples, info, timestamp, config}
//   Latency: the beat accepted in cycle t is on M_AXIS_TDATA in cycle
//   t + PRE_ACQ_DEPTH + 2.
// -----------------------------------------------------------------------------
module hardware_trigger_gen
    import hardware_trigger_gen_pkg::*;
#(
    parameter int SAMPLE_WIDTH      = 16,
    parameter int SAMPLES_PER_CYCLE = 8,
    parameter int PRE_ACQ_DEPTH     = 4,
    parameter int POST_LEN_WIDTH    = 8
) (
    input  logic                                        ACLK,
    input  logic                                        ARESETN,
    input  logic                                        SET_CONFIG,
    input  logic                                        STOP,
    input  logic [SAMPLE_WIDTH-1:0]                     THRESHOLD,
    input  logic [POST_LEN_WIDTH-1:0]                   POST_ACQ_LEN,
    input  logic [SAMPLE_WIDTH*SAMPLES_PER_CYCLE-1:0]   S_AXIS_TDATA,
    output logic                                        M_AXIS_TVALID,
    output logic [SAMPLE_WIDTH*SAMPLES_PER_CYCLE+TRIGGER_INFO_WIDTH+TIMESTAMP_WIDTH+TRIGGER_CONFIG_WIDTH-1:0] M_AXIS_TDATA
);

    localparam int DATA_W = SAMPLE_WIDTH * SAMPLES_PER_CYCLE;
    // Wide enough for PRE_ACQ_DEPTH plus the largest post length.
    localparam int CNT_W  = $clog2(PRE_ACQ_DEPTH + 2**POST_LEN_WIDTH);
    // Largest positive sample: no sample can exceed it, so nothing triggers.
    localparam logic signed [SAMPLE_WIDTH-1:0] THR_NEVER = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

    logic [DATA_W-1:0]                 s_p1;
    logic signed [SAMPLE_WIDTH-1:0]    thr_q;
    logic [POST_LEN_WIDTH-1:0]         post_q;
    logic [TIMESTAMP_WIDTH-1:0]        ts_cnt;

    logic [SAMPLES_PER_CYCLE-1:0]      over_p2;
    logic                              any_over_p2;
    logic                              any_over_prev;
    logic                              hit_p2;
    logic [DATA_W-1:0]                 dl_out;

    trg_state_t                        state;
    logic [CNT_W-1:0]                  count;
    logic [CNT_W-1:0]                  count_load;
    logic [TIMESTAMP_WIDTH-1:0]        ts_frame;
    logic [TRIGGER_CONFIG_WIDTH-1:0]   cfg_now;
    logic [TRIGGER_CONFIG_WIDTH-1:0]   cfg_frame;

    logic                              out_vld;
    logic [DATA_W-1:0]                 out_samples;
    logic [TRIGGER_INFO_WIDTH-1:0]     out_info;
    logic [TIMESTAMP_WIDTH-1:0]        out_ts;
    logic [TRIGGER_CONFIG_WIDTH-1:0]   out_cfg;

    // ---- stage 1: input register, config registers, timestamp ----
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_p1          <= '0;
            thr_q         <= THR_NEVER;
            post_q        <= '0;
            ts_cnt        <= '0;
            any_over_prev <= 1'b0;
        end else begin
            s_p1   <= S_AXIS_TDATA;
            ts_cnt <= ts_cnt + TIMESTAMP_WIDTH'(1);
            if (SET_CONFIG) begin
                thr_q  <= THRESHOLD;
                post_q <= POST_ACQ_LEN;
            end
            // Pretending the previous beat was already over the threshold
            // keeps a level that sits above a freshly loaded threshold from
            // firing; only a genuine rising edge afterwards triggers.
            any_over_prev <= SET_CONFIG ? 1'b1 : any_over_p2;
        end
    end

    // ---- stage 2: per-sample signed compare and edge detection ----
    always_comb begin
        over_p2 = '0;
        for (int j = 0; j < SAMPLES_PER_CYCLE; j++) begin
            over_p2[j] = $signed(s_p1[j*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > thr_q;
        end
    end

    assign any_over_p2 = |over_p2;
    assign hit_p2      = any_over_p2 && !any_over_prev && (state == ST_IDLE)
                         && !STOP && !SET_CONFIG;

    assign count_load  = CNT_W'(PRE_ACQ_DEPTH) + CNT_W'(post_q);
    assign cfg_now     = pack_config(CFG_FIELD_W'(thr_q), CFG_FIELD_W'(post_q));

    // Pre-trigger history: stage-1 samples delayed so that the first frame
    // beat is PRE_ACQ_DEPTH beats older than the trigger beat.
    sample_delay_line #(
        .WIDTH (DATA_W),
        .DEPTH (PRE_ACQ_DEPTH)
    ) u_history (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .samples (s_p1),
        .delayed (dl_out)
    );

    // ---- output stage: frame FSM with registered beat fields ----
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= ST_IDLE;
            count       <= '0;
            ts_frame    <= '0;
            cfg_frame   <= '0;
            out_vld     <= 1'b0;
            out_samples <= '0;
            out_info    <= '0;
            out_ts      <= '0;
            out_cfg     <= '0;
        end else begin
            out_samples <= dl_out;
            out_vld     <= 1'b0;
            out_info    <= '0;
            out_ts      <= '0;
            out_cfg     <= '0;
            if (SET_CONFIG) begin
                // Abort: the partial frame ends without an end flag.
                state <= ST_IDLE;
                count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (hit_p2) begin
                            state     <= ST_ACTIVE;
                            count     <= count_load;
                            ts_frame  <= ts_cnt;
                            cfg_frame <= cfg_now;
                            out_vld   <= 1'b1;
                            out_info  <= make_info(1'b1, count_load == '0);
                            out_ts    <= ts_cnt;
                            out_cfg   <= cfg_now;
                        end
                    end
                    ST_ACTIVE: begin
                        // count is the number of frame beats still to come
                        // after the one currently on the output.
                        if (count == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            count    <= count - CNT_W'(1);
                            out_vld  <= 1'b1;
                            out_info <= make_info(1'b0, count == CNT_W'(1));
                            out_ts   <= ts_frame;
                            out_cfg  <= cfg_frame;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign M_AXIS_TVALID = out_vld;
    assign M_AXIS_TDATA  = {out_samples, out_info, out_ts, out_cfg};

endmodule

// File: tb/tb_hardware_trigger_gen.sv
// -----------------------------------------------------------------------------
// tb_hardware_trigger_gen
//   Randomized, self-checking bench for hardware_trigger_gen. A window-based
//   reference model predicts every output beat from the history of accepted
//   input beats and the frame windows opened by rising threshold crossings.
// -----------------------------------------------------------------------------
module tb_hardware_trigger_gen;
    import hardware_trigger_gen_pkg::*;

    localparam int SW   = 16;
    localparam int SPC  = 8;
    localparam int D    = 4;
    localparam int PW   = 8;
    localparam int DW   = SW * SPC;
    localparam int OW   = DW + TRIGGER_INFO_WIDTH + TIMESTAMP_WIDTH + TRIGGER_CONFIG_WIDTH;
    localparam int MAXC = 4096;

    typedef logic [OW-1:0] wide_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          SET_CONFIG = 1'b0;
    logic          STOP = 1'b0;
    logic [SW-1:0] THRESHOLD = '0;
    logic [PW-1:0] POST_ACQ_LEN = '0;
    logic [DW-1:0] S_AXIS_TDATA = '0;
    logic          M_AXIS_TVALID;
    logic [OW-1:0] M_AXIS_TDATA;

    always #5 ACLK = ~ACLK;

    hardware_trigger_gen #(
        .SAMPLE_WIDTH      (SW),
        .SAMPLES_PER_CYCLE (SPC),
        .PRE_ACQ_DEPTH     (D),
        .POST_LEN_WIDTH    (PW)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .SET_CONFIG    (SET_CONFIG),
        .STOP          (STOP),
        .THRESHOLD     (THRESHOLD),
        .POST_ACQ_LEN  (POST_ACQ_LEN),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA)
    );

    // Reference model state
    logic [DW-1:0] acc [MAXC];
    int            cyc;
    int            m_thr;
    int            m_post;
    bit            m_prev;
    int unsigned   m_ts;
    int            f_start;
    int            f_end;
    int unsigned   f_ts;
    logic [31:0]   f_cfg;

    bit            e_valid;
    logic [7:0]    e_info;
    logic [DW-1:0] e_samples;
    logic [31:0]   e_ts;
    logic [31:0]   e_cfg;

    int n_checks = 0;
    int n_fail   = 0;
    int frames_seen = 0;

    task automatic check_val(input string tag, input wide_t got, input wide_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit beat_over(input logic [DW-1:0] b, input int thr);
        for (int j = 0; j < SPC; j++) begin
            if (int'($signed(b[j*SW +: SW])) > thr) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] make_beat(input int level, input int noise);
        logic [DW-1:0] b;
        int v;
        int peak;
        peak = int'($urandom_range(0, SPC-1));
        for (int j = 0; j < SPC; j++) begin
            v = (j == peak) ? level : level - int'($urandom_range(0, noise));
            if (v < -32768) v = -32768;
            if (v > 32767)  v = 32767;
            b[j*SW +: SW] = 16'(v);
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAXC; i++) acc[i] = '0;
        m_thr     = 32767;
        m_post    = 0;
        m_prev    = 1'b0;
        m_ts      = 0;
        f_start   = 1;
        f_end     = 0;
        e_valid   = 1'b0;
        e_info    = '0;
        e_samples = '0;
        e_ts      = '0;
        e_cfg     = '0;
    endtask

    // Predict the outputs of the next cycle from the inputs now being driven.
    task automatic model_advance();
        logic [DW-1:0] s1;
        bit over;
        bit idle;
        bit hit;
        bit first;
        bit last;
        s1   = (cyc >= 1) ? acc[cyc-1] : '0;
        over = beat_over(s1, m_thr);
        idle = !(cyc >= f_start && cyc <= f_end);
        hit  = over && !m_prev && idle && !STOP && !SET_CONFIG;
        if (SET_CONFIG && f_end > cyc) f_end = cyc;
        if (hit) begin
            f_start = cyc + 1;
            f_end   = cyc + 1 + D + m_post;
            f_ts    = m_ts;
            f_cfg   = {16'(m_thr), 16'(m_post)};
        end
        e_valid   = (cyc + 1 >= f_start) && (cyc + 1 <= f_end);
        first     = e_valid && (cyc + 1 == f_start);
        last      = e_valid && (cyc + 1 == f_end);
        e_info    = e_valid ? {first, last, 4'b0000, 2'b01} : 8'h00;
        e_ts      = e_valid ? f_ts : 32'd0;
        e_cfg     = e_valid ? f_cfg : 32'd0;
        e_samples = (cyc - D - 1 >= 0) ? acc[cyc-D-1] : '0;
        m_prev    = SET_CONFIG ? 1'b1 : over;
        if (SET_CONFIG) begin
            m_thr  = int'($signed(THRESHOLD));
            m_post = int'(POST_ACQ_LEN);
        end
        acc[cyc] = S_AXIS_TDATA;
        m_ts++;
        cyc++;
    endtask

    task automatic check_outputs();
        check_val("tvalid",    wide_t'(M_AXIS_TVALID), wide_t'(e_valid));
        check_val("samples",   wide_t'(M_AXIS_TDATA[OW-1 -: DW]), wide_t'(e_samples));
        check_val("info",      wide_t'(M_AXIS_TDATA[64 +: 8]), wide_t'(e_info));
        check_val("timestamp", wide_t'(M_AXIS_TDATA[32 +: 32]), wide_t'(e_ts));
        check_val("config",    wide_t'(M_AXIS_TDATA[0 +: 32]), wide_t'(e_cfg));
        if (M_AXIS_TVALID && M_AXIS_TDATA[64+7]) frames_seen++;
    endtask

    task automatic tick();
        check_outputs();
        model_advance();
        @(negedge ACLK);
    endtask

    task automatic reset_tick();
        check_outputs();
        acc[cyc] = '0;
        cyc++;
        m_ts = 0;
        @(negedge ACLK);
    endtask

    task automatic beat(input int level);
        S_AXIS_TDATA = make_beat(level, 20);
        tick();
    endtask

    task automatic configure(input int thr, input int post, input int level);
        SET_CONFIG   = 1'b1;
        THRESHOLD    = 16'(thr);
        POST_ACQ_LEN = 8'(post);
        beat(level);
        SET_CONFIG   = 1'b0;
    endtask

    // Advance until the current output is beat n (0-based) of a frame.
    task automatic run_until_frame_beat(input int n, input int level);
        int budget;
        budget = 60;
        while (!(e_valid && cyc == f_start + n) && budget > 0) begin
            beat(level);
            budget--;
        end
        check_val("frame_wait_tvalid", wide_t'(M_AXIS_TVALID), wide_t'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs0;
        int level;
        int run;
        cyc = 0;
        model_reset();
        #1;
        check_val("reset_tvalid", wide_t'(M_AXIS_TVALID), wide_t'(0));
        check_val("reset_tdata",  wide_t'(M_AXIS_TDATA),  wide_t'(0));
        @(negedge ACLK);
        repeat (3) reset_tick();
        ARESETN = 1'b1;

        // Ramp through the threshold, then hold above it: one frame only.
        configure(100, 3, 0);
        fs0 = frames_seen;
        for (int b = 0; b < 30; b++) beat(b * 10);
        for (int b = 0; b < 50; b++) beat(200);
        for (int b = 0; b < 10; b++) beat(0);
        check_val("held_level_frames", wide_t'(frames_seen - fs0), wide_t'(1));

        // Pulses: trigger, ignored re-cross inside window, re-cross right
        // after the last beat.
        fs0 = frames_seen;
        for (int b = 0; b < 30; b++) beat((b == 0 || b == 2 || b == 9) ? 200 : 0);
        check_val("pulse_frames", wide_t'(frames_seen - fs0), wide_t'(2));

        // STOP mid-frame, crossing under STOP, crossing after STOP.
        fs0 = frames_seen;
        for (int b = 0; b < 36; b++) begin
            if (b == 4)  STOP = 1'b1;
            if (b == 16) STOP = 1'b0;
            beat((b == 0 || b == 12 || b == 20) ? 200 : 0);
        end
        check_val("stop_frames", wide_t'(frames_seen - fs0), wide_t'(2));

        // SET_CONFIG during a frame while the input sits above the new level.
        fs0 = frames_seen;
        for (int b = 0; b < 5; b++) beat(0);
        beat(150);
        run_until_frame_beat(1, 150);
        configure(50, 3, 150);
        check_val("abort_tvalid", wide_t'(M_AXIS_TVALID), wide_t'(0));
        for (int b = 0; b < 20; b++) beat(150);
        for (int b = 0; b < 5; b++)  beat(0);
        for (int b = 0; b < 5; b++)  beat(150);
        for (int b = 0; b < 15; b++) beat(0);
        check_val("config_frames", wide_t'(frames_seen - fs0), wide_t'(2));

        // Random levels, STOP and reconfiguration.
        level = 0;
        run   = 0;
        for (int b = 0; b < 800; b++) begin
            if (run == 0) begin
                level = int'($urandom_range(0, 250)) - 50;
                run   = int'($urandom_range(1, 6));
            end
            run--;
            if ($urandom_range(0, 19) == 0) STOP = ~STOP;
            if ($urandom_range(0, 39) == 0) begin
                configure(int'($urandom_range(0, 150)), int'($urandom_range(0, 5)), level);
            end else begin
                beat(level);
            end
        end
        STOP = 1'b0;

        // Asynchronous reset in the middle of a frame.
        configure(100, 5, 0);
        for (int b = 0; b < 10; b++) beat(0);
        beat(200);
        run_until_frame_beat(3, 0);
        ARESETN = 1'b0;
        #1;
        check_val("async_rst_tvalid", wide_t'(M_AXIS_TVALID), wide_t'(0));
        check_val("async_rst_tdata",  wide_t'(M_AXIS_TDATA),  wide_t'(0));
        model_reset();
        repeat (3) reset_tick();
        ARESETN = 1'b1;

        // Reset threshold must never fire, even at full scale.
        fs0 = frames_seen;
        for (int b = 0; b < 30; b++) begin
            S_AXIS_TDATA = make_beat(((b / 3) % 2 == 1) ? 32767 : -32768, 0);
            tick();
        end
        for (int b = 0; b < 12; b++) beat(0);
        check_val("post_reset_frames", wide_t'(frames_seen - fs0), wide_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
